seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the fixed 8-bit multiplier. Adds a WIDTH parameter, a per-operation signed/unsigned mode, a start/busy/done handshake and a synchronous reset. Retires one multiplier bit per clock. Sits between operand registers and the result/display datapath.

---
 rtl/seq_mult_param_if.sv | 22 ++
 rtl/seq_mult_param.sv | 88 ++++++++
 tb/tb_seq_mult_param.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_param_if.sv
// Operand/result bundle for the sequential multiplier: start/busy/done handshake plus datapath.
interface seq_mult_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, mcand, mplier,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, mcand, mplier,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier retiring one multiplier bit per clock.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_mult_param #(
   parameter int unsigned WIDTH = 8
) (
   input logic            clock,
   input logic            reset,
   seq_mult_param_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned AW    = 2 * WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e            state_q;
   logic [AW-1:0]     acc_q;
   logic [WIDTH-1:0]  mcand_q;
   logic              neg_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [WIDTH-1:0]  mcand_mag;
   logic [WIDTH-1:0]  mplier_mag;
   logic [WIDTH:0]    upper_sum;
   logic [AW-1:0]     acc_step;

   always_comb begin
      mcand_mag  = bus.mcand;
      mplier_mag = bus.mplier;
      if (bus.signed_mode && bus.mcand[WIDTH-1]) begin
         mcand_mag = WIDTH'(~bus.mcand + WIDTH'(1));
      end
      if (bus.signed_mode && bus.mplier[WIDTH-1]) begin
         mplier_mag = WIDTH'(~bus.mplier + WIDTH'(1));
      end
      // The extra top accumulator bit catches the add carry before the shift.
      upper_sum = acc_q[AW-1:WIDTH] + {1'b0, mcand_q};
      if (acc_q[0]) begin
         acc_step = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
      end else begin
         acc_step = {1'b0, acc_q[AW-1:1]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         mcand_q     <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.product <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  mcand_q  <= mcand_mag;
                  neg_q    <= bus.signed_mode & (bus.mcand[WIDTH-1] ^ bus.mplier[WIDTH-1]);
                  acc_q    <= {(WIDTH + 1)'(0), mplier_mag};
                  cnt_q    <= '0;
                  bus.busy <= 1'b1;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               if (neg_q) begin
                  bus.product <= (2 * WIDTH)'(0) - acc_q[2*WIDTH-1:0];
               end else begin
                  bus.product <= acc_q[2*WIDTH-1:0];
               end
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: cycle-level latency/arithmetic model plus directed literal checks.
module tb_seq_mult_param;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   seq_mult_param_if #(.WIDTH(8)) b8 ();
   seq_mult_param_if #(.WIDTH(4)) b4 ();

   seq_mult_param #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(b8));
   seq_mult_param #(.WIDTH(4)) dut4 (.clock(clock), .reset(reset), .bus(b4));

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference product from plain integer arithmetic, reduced modulo 2^(2w).
   function automatic logic [63:0] ref_mult(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
      longint mask, sa, sb, p;
      mask = (longint'(1) << w) - 1;
      sa   = longint'(a) & mask;
      sb   = longint'(b) & mask;
      if (s && sa[w-1]) sa -= (longint'(1) << w);
      if (s && sb[w-1]) sb -= (longint'(1) << w);
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Model: result appears WIDTH+1 edges after the accepting edge.
   logic [15:0] e8_prod = '0, e8_pend = '0;
   logic        e8_busy = 1'b0, e8_done = 1'b0;
   int          e8_rem  = 0;
   logic [7:0]  e4_prod = '0, e4_pend = '0;
   logic        e4_busy = 1'b0, e4_done = 1'b0;
   int          e4_rem  = 0;

   always @(posedge clock) begin
      if (reset) begin
         e8_prod = '0; e8_busy = 1'b0; e8_done = 1'b0; e8_rem = 0;
         e4_prod = '0; e4_busy = 1'b0; e4_done = 1'b0; e4_rem = 0;
      end else begin
         e8_done = 1'b0;
         if (e8_busy) begin
            e8_rem--;
            if (e8_rem == 0) begin
               e8_busy = 1'b0; e8_done = 1'b1; e8_prod = e8_pend;
            end
         end else if (b8.start) begin
            e8_pend = 16'(ref_mult(8, 32'(b8.mcand), 32'(b8.mplier), b8.signed_mode));
            e8_busy = 1'b1; e8_rem = 9;
         end
         e4_done = 1'b0;
         if (e4_busy) begin
            e4_rem--;
            if (e4_rem == 0) begin
               e4_busy = 1'b0; e4_done = 1'b1; e4_prod = e4_pend;
            end
         end else if (b4.start) begin
            e4_pend = 8'(ref_mult(4, 32'(b4.mcand), 32'(b4.mplier), b4.signed_mode));
            e4_busy = 1'b1; e4_rem = 5;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("busy8", 64'(b8.busy), 64'(e8_busy));
         check("done8", 64'(b8.done), 64'(e8_done));
         check("product8", 64'(b8.product), 64'(e8_prod));
         check("busy4", 64'(b4.busy), 64'(e4_busy));
         check("done4", 64'(b4.done), 64'(e4_done));
         check("product4", 64'(b4.product), 64'(e4_prod));
      end
   end

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
      b8.start = 1'b1; b8.mcand = a; b8.mplier = b; b8.signed_mode = s;
      @(negedge clock);
      b8.start = 1'b0;
   endtask

   task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic s);
      b4.start = 1'b1; b4.mcand = a; b4.mplier = b; b4.signed_mode = s;
      @(negedge clock);
      b4.start = 1'b0;
   endtask

   // Waits (bounded) for done on the chosen instance, checks product, returns cycles waited.
   task automatic wait_done(input int inst, input logic [63:0] exp, input string name,
                            output int lat);
      logic d;
      lat = 0;
      d   = (inst == 8) ? b8.done : b4.done;
      while (!d && lat < 30) begin
         @(negedge clock);
         lat++;
         d = (inst == 8) ? b8.done : b4.done;
      end
      if (!d) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: done never seen, expected product %0h", name, exp);
      end else begin
         check(name, (inst == 8) ? 64'(b8.product) : 64'(b4.product), exp);
      end
   endtask

   initial begin
      int lat;
      int nd;
      b8.start = 1'b0; b8.signed_mode = 1'b0; b8.mcand = '0; b8.mplier = '0;
      b4.start = 1'b0; b4.signed_mode = 1'b0; b4.mcand = '0; b4.mplier = '0;
      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      check("rst_busy", 64'(b8.busy), 64'd0);
      check("rst_done", 64'(b8.done), 64'd0);
      check("rst_product", 64'(b8.product), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      start8(8'hFF, 8'hFF, 1'b0);
      wait_done(8, 64'hFE01, "u255x255", lat);
      check("lat_u255", 64'(lat), 64'd9);
      @(negedge clock);
      start8(8'hFD, 8'h05, 1'b1);
      wait_done(8, 64'hFFF1, "s_m3x5", lat);
      @(negedge clock);
      start8(8'h80, 8'h80, 1'b1);
      wait_done(8, 64'h4000, "s_m128xm128", lat);
      @(negedge clock);
      start8(8'h7F, 8'h80, 1'b1);
      wait_done(8, 64'hC080, "s_127xm128", lat);
      @(negedge clock);
      start8(8'hFD, 8'h05, 1'b0);
      wait_done(8, 64'h04F1, "u_fdx05", lat);

      // Start held and operands churned mid-run must not disturb the running op.
      @(negedge clock);
      start8(8'd7, 8'd9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         b8.start = 1'b1; b8.mcand = 8'(i * 37 + 11); b8.mplier = 8'hFF; b8.signed_mode = 1'b1;
         @(negedge clock);
      end
      b8.start = 1'b0;
      wait_done(8, 64'h003F, "ignore_7x9", lat);
      repeat (5) @(negedge clock);
      check("hold_product", 64'(b8.product), 64'h003F);

      // Back-to-back: new start issued in the done cycle.
      start8(8'd10, 8'd20, 1'b0);
      wait_done(8, 64'h00C8, "u_10x20", lat);
      start8(8'd2, 8'd3, 1'b0);
      wait_done(8, 64'h0006, "b2b_2x3", lat);
      check("b2b_gap", 64'(lat + 1), 64'd10);

      // Reset sampled at E4 abandons the run.
      @(negedge clock);
      start8(8'hFF, 8'hFF, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_busy", 64'(b8.busy), 64'd0);
      check("midrst_done", 64'(b8.done), 64'd0);
      check("midrst_product", 64'(b8.product), 64'd0);
      reset = 1'b0;
      nd = 0;
      repeat (15) begin
         @(negedge clock);
         if (b8.done) nd++;
      end
      check("no_done_after_rst", 64'(nd), 64'd0);

      start8(8'd0, 8'd200, 1'b0);
      wait_done(8, 64'h0000, "u_0x200", lat);
      check("lat_zero", 64'(lat), 64'd9);

      @(negedge clock);
      start4(4'hF, 4'hF, 1'b0);
      wait_done(4, 64'hE1, "w4_u15x15", lat);
      check("lat_w4", 64'(lat), 64'd5);
      @(negedge clock);
      start4(4'h8, 4'hF, 1'b1);
      wait_done(4, 64'h08, "w4_sm8xm1", lat);

      repeat (3) @(negedge clock);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
